// File: rtl/tc_pkg.sv
// Shared types and constants for the token streamer and its FIFO.
package tc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } streamer_state_t;

    // A zero code marks the end of the encoder's output.
    localparam int TC_TERMINATOR = 0;

endpackage

// File: rtl/token_fifo.sv
// Two-entry synchronous FIFO that holds fetched codes ahead of the output stream.
module token_fifo #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [1:0]            occupancy,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] mem [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            occ;
    logic                  do_push;
    logic                  do_pop;

    assign full      = (occ == 2'd2);
    assign empty     = (occ == 2'd0);
    assign occupancy = occ;
    assign head      = mem[rd_ptr];

    // Pushing into a full FIFO is only allowed when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/token_streamer.sv
// Streams the encoder's non-zero output codes from SRAM as tokens.
// TOKEN_STREAMER_LAST_EN adds an m_last output marking the final token of a run.
module token_streamer
    import tc_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  ram_cs,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   count,
`ifdef TOKEN_STREAMER_LAST_EN
    output logic                  m_last,
`endif
    output streamer_state_t       dbg_state
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_WIDTH:0]   COUNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    streamer_state_t       state;
    streamer_state_t       state_next;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  exhausted;
    logic                  inflight;
    logic                  term;
    logic [ADDR_WIDTH:0]   cnt;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [1:0]            fifo_occ;
    logic [DATA_WIDTH-1:0] fifo_head;

    logic                  launch;
    logic                  ret_zero;
    logic                  term_now;
    logic                  issue;
    logic [2:0]            pending;
    logic [2:0]            occ_after;

    // Stream handshake: a token transfers on any cycle with m_valid && m_ready;
    // m_valid never drops and m_data never changes until that transfer happens.
    assign fifo_pop = m_valid && m_ready;
    assign m_valid  = !fifo_empty;
    assign m_data   = fifo_head;

    assign launch    = start && ((state == IDLE) || (state == DONE));
    assign ret_zero  = inflight && (ram_dout == DATA_WIDTH'(TC_TERMINATOR));
    assign term_now  = term || ret_zero;
    assign fifo_push = inflight && !term && !ret_zero && (!fifo_full || fifo_pop);

    // Buffered plus in-flight codes after this cycle's pop; a new read must still fit.
    assign pending   = 3'(fifo_occ) + 3'(inflight) - 3'(fifo_pop);
    assign occ_after = 3'(fifo_occ) - 3'(fifo_pop) + 3'(fifo_push);

    // A zero arriving this cycle already blocks issue so no read is wasted past it.
    assign issue = (state == FETCH) && !term_now && !exhausted && (pending < 3'd2);

    assign ram_cs    = issue;
    assign ram_addr  = addr;
    assign busy      = (state == FETCH) || (state == DRAIN);
    assign done      = (state == DONE);
    assign count     = cnt;
    assign dbg_state = state;

`ifdef TOKEN_STREAMER_LAST_EN
    // The head is final when it is the only entry and no further code can arrive.
    assign m_last = m_valid && (fifo_occ == 2'd1) && (term_now || (exhausted && !inflight));
`endif

    token_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (ram_dout),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (fifo_occ),
        .head      (fifo_head)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = FETCH;
            end
            FETCH: begin
                // Skipping DRAIN when the FIFO empties here keeps done one cycle after the last token.
                if (ret_zero || (inflight && exhausted)) begin
                    state_next = (occ_after == 3'd0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (occ_after == 3'd0) state_next = DONE;
            end
            DONE: begin
                if (start) state_next = FETCH;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            exhausted <= 1'b0;
            inflight  <= 1'b0;
            term      <= 1'b0;
            cnt       <= '0;
        end else begin
            state    <= state_next;
            inflight <= issue;
            if (launch) begin
                addr      <= '0;
                exhausted <= 1'b0;
                term      <= 1'b0;
                cnt       <= '0;
            end else begin
                if (issue) begin
                    addr <= addr + 1'b1;
                    if (addr == ADDR_LAST) exhausted <= 1'b1;
                end
                if (ret_zero) term <= 1'b1;
                if (fifo_pop && (cnt != COUNT_MAX)) cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_token_streamer.sv
// Directed bench for token_streamer: SRAM model, token scoreboard, timing and reset checks.
module tb_token_streamer;
    import tc_pkg::*;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          start;
    logic          ram_cs;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          busy;
    logic          done;
    logic [AW:0]   count;
    streamer_state_t dbg_state;
`ifdef TOKEN_STREAMER_LAST_EN
    logic          m_last;
`endif

    logic [DW-1:0] mem [16];
    logic [DW-1:0] exp_q [$];
    int            n_checks;
    int            n_fail;
    int            reads;
    bit            stalled;
    logic [DW-1:0] held;

    token_streamer #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ram_cs    (ram_cs),
        .ram_addr  (ram_addr),
        .ram_dout  (ram_dout),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .busy      (busy),
        .done      (done),
        .count     (count),
`ifdef TOKEN_STREAMER_LAST_EN
        .m_last    (m_last),
`endif
        .dbg_state (dbg_state)
    );

    // Clock and SRAM model with one-cycle read latency.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_cs) begin
            ram_dout <= mem[ram_addr];
            reads    <= reads + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each handshake and checks stall stability.
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid_hold", 32'(m_valid), 32'd1);
                check("stall_data_hold", 32'(m_data), 32'(held));
            end
            if (m_valid && m_ready) begin
                check("token_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("token_data", 32'(m_data), 32'(exp_q.pop_front()));
`ifdef TOKEN_STREAMER_LAST_EN
                    if (m_last) check("last_is_final", 32'(exp_q.size()), 32'd0);
`endif
                end
            end
            stalled = m_valid && !m_ready;
            held    = m_data;
        end
    end

    // kind 0: 41,42,43,00  kind 1: 1..16  kind 2: all zero  kind 3: random with a zero
    task automatic load_mem(input int kind);
        int zpos;
        zpos = $urandom_range(1, 15);
        for (int i = 0; i < 16; i++) begin
            case (kind)
                0:       mem[i] = (i < 3) ? DW'(8'h41 + i) : '0;
                1:       mem[i] = DW'(i + 1);
                2:       mem[i] = '0;
                default: mem[i] = (i == zpos) ? '0 : DW'($urandom_range(1, 255));
            endcase
        end
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            if (mem[i] == '0) break;
            exp_q.push_back(mem[i]);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // mode 0: always ready, 1: toggling, 2: random
    task automatic run_until_done(input int mode, input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #1;
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ~m_ready;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check("run_completes", 32'(ok), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ram_cs"}, 32'(ram_cs), 32'd0);
        check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_m_data"}, 32'(m_data), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    initial begin
        bit hit;
        n_checks = 0;
        n_fail   = 0;
        reads    = 0;
        stalled  = 1'b0;
        held     = '0;
        ram_dout = '0;
        rst      = 1'b1;
        start    = 1'b0;
        m_ready  = 1'b0;
        load_mem(2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        #1 rst = 1'b0;

        // Run 1: exact first-token latency and done timing.
        load_mem(0);
        m_ready = 1'b1;
        pulse_start();
        @(negedge clk);
        check("r1_k1_ram_cs", 32'(ram_cs), 32'd1);
        check("r1_k1_ram_addr", 32'(ram_addr), 32'd0);
        check("r1_k1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("r1_k2_m_valid", 32'(m_valid), 32'd0);
        @(negedge clk);
        check("r1_k3_m_valid", 32'(m_valid), 32'd1);
        check("r1_k3_m_data", 32'(m_data), 32'h41);
        @(negedge clk);
        check("r1_k4_m_data", 32'(m_data), 32'h42);
        @(negedge clk);
        check("r1_k5_m_data", 32'(m_data), 32'h43);
        check("r1_k5_done", 32'(done), 32'd0);
        @(negedge clk);
        check("r1_k6_done", 32'(done), 32'd1);
        check("r1_k6_count", 32'(count), 32'd3);
        check("r1_k6_m_valid", 32'(m_valid), 32'd0);
        check("r1_queue_empty", 32'(exp_q.size()), 32'd0);

        // Run 2: start from DONE, toggling ready.
        load_mem(0);
        pulse_start();
        @(negedge clk);
        check("r2_done_dropped", 32'(done), 32'd0);
        check("r2_count_cleared", 32'(count), 32'd0);
        run_until_done(1, 200);
        check("r2_count", 32'(count), 32'd3);
        check("r2_queue_empty", 32'(exp_q.size()), 32'd0);

        // Run 3: no terminator, every address read exactly once.
        load_mem(1);
        m_ready = 1'b1;
        @(negedge clk);
        reads = 0;
        pulse_start();
        run_until_done(0, 200);
        check("r3_count", 32'(count), 32'd16);
        check("r3_reads", 32'(reads), 32'd16);
        check("r3_queue_empty", 32'(exp_q.size()), 32'd0);

        // Run 4: terminator at address 0.
        load_mem(2);
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        check("r4_k2_done", 32'(done), 32'd0);
        @(negedge clk);
        check("r4_k3_done", 32'(done), 32'd1);
        check("r4_k3_count", 32'(count), 32'd0);

        // Run 5: random contents and random backpressure.
        for (int r = 0; r < 3; r++) begin
            load_mem(3);
            pulse_start();
            run_until_done(2, 400);
            check("r5_queue_empty", 32'(exp_q.size()), 32'd0);
        end

        // Run 6: reset mid-run, then a clean restart from address 0.
        load_mem(1);
        m_ready = 1'b1;
        pulse_start();
        hit = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (count == 5'd2) begin
                hit = 1'b1;
                break;
            end
        end
        check("r6_reached_two", 32'(hit), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midrun_reset");
        exp_q.delete();
        #1 rst = 1'b0;
        load_mem(1);
        pulse_start();
        @(negedge clk);
        check("r6_restart_addr", 32'(ram_addr), 32'd0);
        check("r6_restart_cs", 32'(ram_cs), 32'd1);
        run_until_done(0, 200);
        check("r6_count", 32'(count), 32'd16);
        check("r6_queue_empty", 32'(exp_q.size()), 32'd0);

        // Run 7: start while busy is ignored.
        load_mem(0);
        m_ready = 1'b0;
        pulse_start();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("r7_busy", 32'(busy), 32'd1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        run_until_done(2, 200);
        check("r7_count", 32'(count), 32'd3);
        check("r7_queue_empty", 32'(exp_q.size()), 32'd0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/token_streamer.md
# token_streamer

Downstream stage of the encoder. Once `done` rises on the encoder, this block reads the encoder's output-code SRAM from address 0 upward. It emits each non-zero code as one token on a valid/ready stream, and stops at the first zero code (the codebase's terminator) or after the last address. A 2-entry prefetch buffer hides the SRAM's 1-cycle read latency, so the block sustains one token per cycle under no backpressure.

## Interface
- `ADDR_WIDTH`, 4: code SRAM address width; depth is 2^ADDR_WIDTH.
- `DATA_WIDTH`, 8: code width.

- `clk`  in  1  clock; one clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  launch pulse; sampled only in IDLE or DONE.
- `ram_cs`  out  1  SRAM read strobe; high only in cycles that issue a read.
- `ram_addr`  out  ADDR_WIDTH  SRAM read address.
- `ram_dout`  in  DATA_WIDTH  SRAM read data, valid the cycle after `ram_cs`.
- `m_valid`  out  1  token available.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  DATA_WIDTH  token code.
- `busy`  out  1  high in FETCH and DRAIN.
- `done`  out  1  sticky completion flag, held in DONE.
- `count`  out  ADDR_WIDTH+1  tokens accepted in the current run.

## Operation
- Reset values:
  - Outputs: `ram_cs`=0, `ram_addr`=0, `m_valid`=0, `m_data`=0, `busy`=0, `done`=0, `count`=0.
  - Internal: FIFO empty, in-flight flag=0, terminator flag=0, state=IDLE.
- States:
  - IDLE: `start`=1 → FETCH. Clears address, `count` and flags.
  - FETCH: issues reads. Leaves for DRAIN when a zero is returned, or when the read of address 2^ADDR_WIDTH−1 has returned.
  - DRAIN: no reads. Goes to DONE when the FIFO is empty and nothing is in flight.
  - DONE: `done`=1. `start`=1 → FETCH with the same clearing as IDLE, and `done` drops.
- Read issue rule: a read is issued in FETCH iff:
  - the terminator flag is clear,
  - the address is not exhausted, and
  - FIFO occupancy + in-flight − pop < 2, where pop = `m_valid && m_ready`.
- Each issued read increments `ram_addr` after issue.
- Returned data:
  - Non-zero data is pushed to the FIFO.
  - Zero data sets the terminator flag and is not pushed; it is never emitted.
  - Any read returning after the terminator is discarded.
- `m_valid`/`m_data` come from the FIFO head register. `m_data` holds stable while `m_valid && !m_ready`.
- `count` increments on each handshake and saturates at 2^ADDR_WIDTH (the maximum possible).
- `start` while `busy` is ignored.
- Reset mid-run: all state clears at once, and a pending SRAM return is ignored.

## Timing
- `start` sampled at edge k.
- Cycle k+1: `ram_cs`=1, `ram_addr`=0.
- Cycle k+2: data on `ram_dout`; pushed at the end of k+2.
- `m_valid`=1 from cycle k+3, so first-token latency is 3 cycles.
- Steady state with `m_ready`=1: one token per cycle, with no bubbles.
- Under backpressure: at most 2 buffered tokens plus 1 in flight. A full FIFO with no pop blocks issue, so no data is ever dropped.
- `done` rises the cycle after the last token handshake, or 3 cycles after `start` if address 0 holds zero.

## Configuration
- `TOKEN_STREAMER_LAST_EN` defined:
  - Adds output `m_last` (1 bit).
  - `m_last` is asserted with the final token of a run: the FIFO head is the last entry, and either the terminator is seen or addresses are exhausted, with nothing in flight.
  - The FIFO lookahead needed to know this adds no cycles of latency.
  - If the final zero arrives after the last non-zero token has already been accepted, `m_last` is not produced for that run.
- Undefined: no `m_last` port. Behaviour is otherwise identical.

## Structure
- Shared package `tc_pkg`:
  - `streamer_state_t` enum: IDLE, FETCH, DRAIN, DONE.
  - Terminator code constant `TC_TERMINATOR` = 0.
- Sub-module `token_fifo`: 2-entry synchronous FIFO (DATA_WIDTH). Ports: push, pop, full, empty, occupancy, head.

## Test plan
- SRAM = 41,42,43,00,…; `m_ready`=1 → tokens 41,42,43 on consecutive cycles k+3..k+5; `count`=3; `done` at k+6.
- Same contents, `m_ready` toggling 1/0 → identical token order, no duplicates or drops; `m_data` stable while stalled.
- ADDR_WIDTH=4, SRAM = 1..16 with no zero → 16 tokens; `count`=16; no read past address 15.
- SRAM[0]=00 → zero tokens; `count`=0; `done`=1 at k+3.
- `rst` asserted mid-run after 2 tokens → all outputs return to reset values next cycle. A subsequent `start` restarts from address 0.
- `start` pulsed while `busy` → ignored. `start` in DONE → second full run with `count` restarted from 0.
